// File: rtl/spi_ram_pkg.sv
// Shared command codes and FSM state encoding for the SPI-to-RAM command controller.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPI_OP  = 2'd1,
        RD_CAPT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM, read-first, registered dout; contents are never reset.
module spi_ram_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [ADDR_SIZE-1:0] din,
    output logic [ADDR_SIZE-1:0] dout
);

    logic [ADDR_SIZE-1:0] mem_array [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_array[addr] <= din;
            end
            dout <= mem_array[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI command controller sharing one RAM with a local host port, SPI has priority.
// Define SPI_RAM_AUTOINC_EN to post-increment wr_addr/rd_addr after each data op.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [ADDR_SIZE+1:0] rx_data,
    output logic                 tx_valid,
    output logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [ADDR_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [ADDR_SIZE-1:0] host_rdata,
    output logic                 cmd_ovf
);

    state_t               state_reg, state_next;
    logic                 spi_pend_reg;
    logic [1:0]           pend_cmd_reg;
    logic [ADDR_SIZE-1:0] pend_payload_reg;
    logic [ADDR_SIZE-1:0] wr_addr_reg, rd_addr_reg;
    logic                 tx_valid_reg, host_rvalid_reg, cmd_ovf_reg;
    logic [ADDR_SIZE-1:0] tx_data_reg;

    logic                 mem_en, mem_we;
    logic [ADDR_SIZE-1:0] mem_addr, mem_din, mem_dout;

    logic [1:0]           rx_cmd;
    logic [ADDR_SIZE-1:0] rx_payload;
    logic                 busy, rx_accept, data_op_accept, spi_wr_op, spi_rd_op;

    assign rx_cmd     = rx_data[ADDR_SIZE+1:ADDR_SIZE];
    assign rx_payload = rx_data[ADDR_SIZE-1:0];

    // Any SPI op still pending or in flight makes a new command an overflow.
    assign busy           = spi_pend_reg | (state_reg != IDLE);
    assign rx_accept      = rx_valid & ~busy;
    assign data_op_accept = rx_accept & ((rx_cmd == CMD_WR_DATA) | (rx_cmd == CMD_RD_DATA));
    assign spi_wr_op      = (state_reg == SPI_OP) & (pend_cmd_reg == CMD_WR_DATA);
    assign spi_rd_op      = (state_reg == SPI_OP) & (pend_cmd_reg == CMD_RD_DATA);

    // A data op jumps straight to SPI_OP so the RAM is accessed on the following edge.
    always_comb begin
        state_next = state_reg;
        host_gnt   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = host_addr;
        mem_din    = host_wdata;
        case (state_reg)
            IDLE: begin
                host_gnt = host_req & ~spi_pend_reg;
                if (host_gnt) begin
                    mem_en = 1'b1;
                    mem_we = host_we;
                end
                if (data_op_accept | spi_pend_reg) begin
                    state_next = SPI_OP;
                end
            end
            SPI_OP: begin
                mem_en     = 1'b1;
                mem_we     = spi_wr_op;
                mem_addr   = spi_wr_op ? wr_addr_reg : rd_addr_reg;
                mem_din    = pend_payload_reg;
                state_next = spi_wr_op ? IDLE : RD_CAPT;
            end
            RD_CAPT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            spi_pend_reg     <= 1'b0;
            pend_cmd_reg     <= CMD_WR_ADDR;
            pend_payload_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (data_op_accept) begin
                spi_pend_reg     <= 1'b1;
                pend_cmd_reg     <= rx_cmd;
                pend_payload_reg <= rx_payload;
            end else if (state_reg == SPI_OP) begin
                spi_pend_reg <= 1'b0;
            end
        end
    end

    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = 1;

    // Address loads take precedence over the post-increment; the add wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_reg <= '0;
            rd_addr_reg <= '0;
        end else begin
            if (rx_accept && rx_cmd == CMD_WR_ADDR) begin
                wr_addr_reg <= rx_payload;
            end
`ifdef SPI_RAM_AUTOINC_EN
            else if (spi_wr_op) begin
                wr_addr_reg <= wr_addr_reg + ADDR_ONE;
            end
`endif
            if (rx_accept && rx_cmd == CMD_RD_ADDR) begin
                rd_addr_reg <= rx_payload;
            end
`ifdef SPI_RAM_AUTOINC_EN
            else if (spi_rd_op) begin
                rd_addr_reg <= rd_addr_reg + ADDR_ONE;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_reg    <= 1'b0;
            tx_data_reg     <= '0;
            host_rvalid_reg <= 1'b0;
            cmd_ovf_reg     <= 1'b0;
        end else begin
            if (state_reg == RD_CAPT) begin
                tx_valid_reg <= 1'b1;
                tx_data_reg  <= mem_dout;
            end else if (rx_valid) begin
                tx_valid_reg <= 1'b0;
            end
            host_rvalid_reg <= host_gnt & ~host_we;
            cmd_ovf_reg     <= rx_valid & busy;
        end
    end

    spi_ram_mem #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_mem (
        .clk (clk),
        .en  (mem_en),
        .we  (mem_we),
        .addr(mem_addr),
        .din (mem_din),
        .dout(mem_dout)
    );

    assign tx_valid    = tx_valid_reg;
    assign tx_data     = tx_data_reg;
    assign host_rvalid = host_rvalid_reg;
    // RAM dout is unreset, so expose it only while the read is valid.
    assign host_rdata  = host_rvalid_reg ? mem_dout : '0;
    assign cmd_ovf     = cmd_ovf_reg;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scenario bench for spi_ram_ctrl: queued expectations checked as tx/host read data appears.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_data = '0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       cmd_ovf;

    int checks = 0;
    int failures = 0;
    logic [7:0] tx_q[$];
    logic [7:0] host_q[$];
    logic [7:0] tx_exp, host_exp;
    logic       tx_prev = 1'b0;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .cmd_ovf(cmd_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Scoreboard: compare each new tx word and each host read against the queue.
    always @(negedge clk) begin
        if (tx_valid && !tx_prev) begin
            checks++;
            if (tx_q.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected got=%h expected=none", tx_data);
            end else begin
                tx_exp = tx_q.pop_front();
                if (tx_data !== tx_exp) begin
                    failures++;
                    $display("FAIL tx_data got=%h expected=%h", tx_data, tx_exp);
                end else
                    $display("tx_data %h ok", tx_data);
            end
        end
        tx_prev <= tx_valid;
        if (host_rvalid) begin
            checks++;
            if (host_q.size() == 0) begin
                failures++;
                $display("FAIL host_unexpected got=%h expected=none", host_rdata);
            end else begin
                host_exp = host_q.pop_front();
                if (host_rdata !== host_exp) begin
                    failures++;
                    $display("FAIL host_rdata got=%h expected=%h", host_rdata, host_exp);
                end else
                    $display("host_rdata %h ok", host_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_cmd(input logic [1:0] c, input logic [7:0] p);
        rx_data  = {c, p};
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        $display("spi cmd=%b payload=%h", c, p);
    endtask

    task automatic spi_op(input logic [1:0] c, input logic [7:0] p);
        spi_cmd(c, p);
        tick();
        tick();
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b1) begin
            failures++;
            $display("FAIL host_wr_gnt addr=%h got=%b expected=1", a, host_gnt);
        end else
            $display("host write %h <= %h", a, d);
        tick();
        host_req = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, input logic [7:0] exp_d);
        host_q.push_back(exp_d);
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b1) begin
            failures++;
            $display("FAIL host_rd_gnt addr=%h got=%b expected=1", a, host_gnt);
        end
        tick();
        host_req = 1'b0;
        @(negedge clk);
        checks++;
        if (host_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL host_rvalid addr=%h got=%b expected=1", a, host_rvalid);
        end else
            $display("host read %h", a);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks += 6;
        if (tx_valid !== 1'b0)   begin failures++; $display("FAIL rst_tx_valid got=%b expected=0", tx_valid); end
        if (tx_data !== 8'h00)   begin failures++; $display("FAIL rst_tx_data got=%h expected=00", tx_data); end
        if (host_rvalid !== 1'b0) begin failures++; $display("FAIL rst_host_rvalid got=%b expected=0", host_rvalid); end
        if (host_rdata !== 8'h00) begin failures++; $display("FAIL rst_host_rdata got=%h expected=00", host_rdata); end
        if (cmd_ovf !== 1'b0)    begin failures++; $display("FAIL rst_cmd_ovf got=%b expected=0", cmd_ovf); end
        if (host_gnt !== 1'b0)   begin failures++; $display("FAIL rst_host_gnt got=%b expected=0", host_gnt); end
        $display("reset state checked");
        tick();
    endtask

    task automatic test_spi_write_read();
        spi_op(CMD_WR_ADDR, 8'h10);
        spi_op(CMD_WR_DATA, 8'hA5);
        spi_op(CMD_RD_ADDR, 8'h10);
        tx_q.push_back(8'hA5);
        spi_cmd(CMD_RD_DATA, 8'h00);
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL rd_lat_c1 got=%b expected=0", tx_valid); end
        tick();
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL rd_lat_c2 got=%b expected=0", tx_valid); end
        tick();
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1) begin failures++; $display("FAIL rd_lat_c3 got=%b expected=1", tx_valid); end
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            failures++;
            $display("FAIL tx_hold got=%b/%h expected=1/a5", tx_valid, tx_data);
        end
        tick();
        spi_cmd(CMD_WR_ADDR, 8'h00);
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_clear got=%b expected=0", tx_valid); end
        tick();
    endtask

    task automatic test_host_conflict();
        spi_op(CMD_WR_ADDR, 8'h20);
        spi_op(CMD_WR_DATA, 8'h77);
        spi_op(CMD_RD_ADDR, 8'h20);
        tx_q.push_back(8'h77);
        rx_data = {CMD_RD_DATA, 8'h00};
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h3C;
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b0) begin failures++; $display("FAIL conflict_gnt_c1 got=%b expected=0", host_gnt); end
        tick();
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b0) begin failures++; $display("FAIL conflict_gnt_c2 got=%b expected=0", host_gnt); end
        tick();
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b1) begin failures++; $display("FAIL conflict_gnt_c3 got=%b expected=1", host_gnt); end
        tick();
        host_req = 1'b0;
        $display("host write 20 <= 3c after spi read");
        host_read(8'h20, 8'h3C);
        spi_op(CMD_RD_ADDR, 8'h20);
        tx_q.push_back(8'h3C);
        spi_op(CMD_RD_DATA, 8'h00);
        tick();
    endtask

    task automatic test_overflow();
        host_write(8'h90, 8'h00);
        spi_op(CMD_WR_ADDR, 8'h40);
        rx_data = {CMD_WR_DATA, 8'h5A};
        rx_valid = 1'b1;
        tick();
        rx_data = {CMD_WR_ADDR, 8'h90};
        @(negedge clk);
        checks++;
        if (cmd_ovf !== 1'b0) begin failures++; $display("FAIL ovf_c1 got=%b expected=0", cmd_ovf); end
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ovf !== 1'b1) begin failures++; $display("FAIL ovf_c2 got=%b expected=1", cmd_ovf); end
        tick();
        @(negedge clk);
        checks++;
        if (cmd_ovf !== 1'b0) begin failures++; $display("FAIL ovf_c3 got=%b expected=0", cmd_ovf); end
        tick();
        $display("overflow pulse checked");
        spi_op(CMD_WR_DATA, 8'h6B);
        host_read(8'h90, 8'h00);
`ifdef SPI_RAM_AUTOINC_EN
        host_read(8'h40, 8'h5A);
        host_read(8'h41, 8'h6B);
`else
        host_read(8'h40, 8'h6B);
`endif
    endtask

    task automatic test_autoinc();
        spi_op(CMD_WR_ADDR, 8'hFF);
        spi_op(CMD_WR_DATA, 8'h11);
        spi_op(CMD_WR_DATA, 8'h22);
        spi_op(CMD_RD_ADDR, 8'hFF);
`ifdef SPI_RAM_AUTOINC_EN
        host_read(8'hFF, 8'h11);
        host_read(8'h00, 8'h22);
        tx_q.push_back(8'h11);
        spi_op(CMD_RD_DATA, 8'h00);
        tx_q.push_back(8'h22);
        spi_op(CMD_RD_DATA, 8'h00);
`else
        host_read(8'hFF, 8'h22);
        tx_q.push_back(8'h22);
        spi_op(CMD_RD_DATA, 8'h00);
        tx_q.push_back(8'h22);
        spi_op(CMD_RD_DATA, 8'h00);
`endif
        tick();
    endtask

    task automatic test_reset_mid_read();
        spi_op(CMD_RD_ADDR, 8'h20);
        spi_cmd(CMD_RD_DATA, 8'h00);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL midrst_tx_valid got=%b expected=0", tx_valid); end
        tick();
        tick();
        rst_n = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h00;
        @(negedge clk);
        checks += 2;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL postrst_tx_valid got=%b expected=0", tx_valid); end
        if (host_gnt !== 1'b1) begin failures++; $display("FAIL postrst_idle_gnt got=%b expected=1", host_gnt); end
        #1;
        host_req = 1'b0;
        tick();
        $display("reset during read capture checked");
        spi_op(CMD_RD_ADDR, 8'h20);
        tx_q.push_back(8'h3C);
        spi_op(CMD_RD_DATA, 8'h00);
        tick();
    endtask

    initial begin
        test_reset();
        test_spi_write_read();
        test_host_conflict();
        test_overflow();
        test_autoinc();
        test_reset_mid_read();
        repeat (3) tick();
        checks++;
        if (tx_q.size() != 0) begin failures++; $display("FAIL tx_queue_left got=%0d expected=0", tx_q.size()); end
        checks++;
        if (host_q.size() != 0) begin failures++; $display("FAIL host_queue_left got=%0d expected=0", host_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
